// File: rtl/wsacc_pkg.sv
// Shared types and default widths for the wsacc PE sequencer.
package wsacc_pkg;

    localparam int WSACC_DATA_WIDTH      = 8;
    localparam int WSACC_OUTPUT_WIDTH    = 32;
    localparam int WSACC_WINDOW_ELEMENTS = 9;
    localparam int WSACC_COUNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } wsacc_ctrl_state_t;

endpackage

// File: rtl/wsacc_pipe_stage.sv
// Single valid/ready register slice; data holds whenever the slot is not reloaded.
module wsacc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot can take new data when empty or being drained this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/wsacc_pe_ctrl.sv
// Weight-stationary PE sequencer: loads a weight window, then streams activation
// windows through a two-slot pipeline (window register, result register).
module wsacc_pe_ctrl
    import wsacc_pkg::*;
#(
    parameter int dataWidth      = WSACC_DATA_WIDTH,
    parameter int outputWidth    = WSACC_OUTPUT_WIDTH,
    parameter int windowElements = WSACC_WINDOW_ELEMENTS,
    parameter int countWidth     = WSACC_COUNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start,
    input  logic [countWidth-1:0]               num_windows,
    output logic                                busy,
    output logic                                done,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [dataWidth-1:0]                w_data,
    output logic                                pe_weight_wr_en,
    output logic [3:0]                          pe_weight_addr,
    output logic [dataWidth-1:0]                pe_weight_o,
    input  logic                                act_valid,
    output logic                                act_ready,
    input  logic [windowElements*dataWidth-1:0] act_data,
    output logic [windowElements*dataWidth-1:0] pe_data_o,
    input  logic [outputWidth-1:0]              pe_result_i,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [outputWidth-1:0]              res_data
);

    localparam int WinW = windowElements * dataWidth;
    localparam logic [4:0] WLast = 5'(windowElements - 1);
    localparam logic [countWidth-1:0] CntOne = countWidth'(1);

    wsacc_ctrl_state_t     state_q, state_d;
    logic [4:0]            wcnt_q, wcnt_d;
    logic [countWidth-1:0] num_q, num_d;
    logic [countWidth-1:0] issued_q, issued_d;
    logic [countWidth-1:0] retired_q, retired_d;

    logic s1_in_ready, s1_valid, s2_in_ready;
    logic w_hs, act_hs, res_hs;

    assign w_hs   = (state_q == LOAD) && w_valid;
    assign act_hs = act_valid && act_ready;
    assign res_hs = res_valid && res_ready;

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign w_ready         = (state_q == LOAD);
    assign pe_weight_wr_en = w_hs;
    assign pe_weight_addr  = wcnt_q[3:0];
    assign pe_weight_o     = (state_q == LOAD) ? w_data : '0;

    // Issue stops at the job length so surplus windows stay upstream.
    assign act_ready = (state_q == RUN) && (issued_q < num_q) && s1_in_ready;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        num_d     = num_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d = num_windows;
                    if (num_windows == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = LOAD;
                        wcnt_d    = '0;
                        issued_d  = '0;
                        retired_d = '0;
                    end
                end
            end
            LOAD: begin
                if (w_hs) begin
                    if (wcnt_q == WLast) begin
                        wcnt_d  = '0;
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + 5'd1;
                    end
                end
            end
            RUN: begin
                if (act_hs) issued_d = issued_q + CntOne;
                if (res_hs) retired_d = retired_q + CntOne;
                if (retired_q == num_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
        end
    end

    wsacc_pipe_stage #(.W(WinW)) u_s1 (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid_i  (act_hs),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (act_data),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (pe_data_o)
    );

    // The PE is combinational, so its result is valid whenever S1 holds a window.
    wsacc_pipe_stage #(.W(outputWidth)) u_s2 (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (pe_result_i),
        .out_valid_o (res_valid),
        .out_ready_i (res_ready),
        .out_data_o  (res_data)
    );

endmodule
